// File: rtl/store_checker_pkg.sv
// Shared types and default constants for the store checker and its store log.
package store_checker_pkg;

   // Run state: RUN until a terminating store or watchdog expiry, then absorbing.
   typedef enum logic [1:0] {
      RUN,
      PASS,
      FAIL,
      TMO
   } chk_state_t;

   // One logged store as seen on the data-memory write bus.
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } store_entry_t;

   localparam logic [31:0] DEF_PASS_ADDR    = 32'd100;
   localparam logic [31:0] DEF_PASS_DATA    = 32'd7;
   localparam logic [31:0] DEF_SCRATCH_ADDR = 32'd96;
   localparam int          DEF_TIMEOUT      = 1024;
   localparam int          DEF_LOG_DEPTH    = 8;

   localparam logic [15:0] STORE_COUNT_MAX  = 16'hFFFF;

endpackage

// File: rtl/store_log_fifo.sv
// First-word-fall-through FIFO holding accepted stores for readback.
// DEPTH must be a power of two >= 2; pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter.
module store_log_fifo
   import store_checker_pkg::*;
#(
   parameter int  DEPTH   = DEF_LOG_DEPTH,
   parameter type entry_t = store_entry_t
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push_i,
   input  entry_t din_i,
   input  logic   pop_i,
   output logic   full_o,
   output logic   empty_o,
   output entry_t head_o,
   output logic   overflow_o
);

   localparam int               ADDR_W  = $clog2(DEPTH);
   localparam int               PTR_W   = ADDR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             overflow_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                    (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

   // A pop on a full FIFO frees the slot the simultaneous push needs.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   assign head_o     = mem_q[rd_ptr_q[ADDR_W-1:0]];
   assign overflow_o = overflow_q;

   // Next pointer values for accepted pushes and pops.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   // Pointer and sticky overflow registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (push_i && !do_push) overflow_q <= 1'b1;
      end
   end

   // Storage array; cleared on reset so the head reads zero while empty after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the array is reset on purpose: a mid-run reset must wipe logged stores and zero the head.
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push) begin
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= din_i;
      end
   end

endmodule

// File: rtl/store_checker.sv
// Self-check stage on the processor's data-memory write bus: classifies
// stores into pass / scratch / illegal, runs a cycle watchdog and logs
// every store accepted while the run is live.
module store_checker
   import store_checker_pkg::*;
#(
   parameter logic [31:0] PASS_ADDR    = DEF_PASS_ADDR,
   parameter logic [31:0] PASS_DATA    = DEF_PASS_DATA,
   parameter logic [31:0] SCRATCH_ADDR = DEF_SCRATCH_ADDR,
   parameter int          TIMEOUT      = DEF_TIMEOUT,
   parameter int          LOG_DEPTH    = DEF_LOG_DEPTH
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   input  logic        log_pop,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic        timeout,
   output logic [15:0] store_count,
   output logic [31:0] cycle_count,
   output logic        log_valid,
   output logic [31:0] log_addr,
   output logic [31:0] log_data,
   output logic        log_overflow
);

   // Watchdog fires on the RUN cycle that brings cycle_count up to TIMEOUT.
   localparam logic [31:0] CYCLE_LAST = 32'(TIMEOUT - 1);

   chk_state_t   state_q;
   logic         pass_q, fail_q, timeout_q, done_q;
   logic [15:0]  store_count_q, store_count_d;
   logic [31:0]  cycle_count_q, cycle_count_d;

   logic         running;
   logic         store_vld;
   logic         is_pass_store;
   logic         is_scratch_store;
   logic         wd_expire;

   store_entry_t log_din;
   store_entry_t log_head;
   logic         log_empty;
   logic         log_full_unused;  // overflow flag already reports the full case

   assign running          = (state_q == RUN);
   assign store_vld        = running && MemWrite;
   assign is_pass_store    = (DataAdr == PASS_ADDR) && (WriteData == PASS_DATA);
   assign is_scratch_store = (DataAdr == SCRATCH_ADDR);
   assign wd_expire        = running && (cycle_count_q == CYCLE_LAST);

   assign log_din = '{addr: DataAdr, data: WriteData};

   // Run FSM with registered verdict flags; a terminating store beats watchdog expiry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= RUN;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         timeout_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (store_vld && is_pass_store) begin
                  state_q <= PASS;
                  pass_q  <= 1'b1;
                  done_q  <= 1'b1;
               end else if (store_vld && !is_scratch_store) begin
                  state_q <= FAIL;
                  fail_q  <= 1'b1;
                  done_q  <= 1'b1;
               end else if (wd_expire) begin
                  state_q   <= TMO;
                  timeout_q <= 1'b1;
                  done_q    <= 1'b1;
               end
            end
            default: state_q <= state_q;
         endcase
      end
   end

   // Counters advance only while the run is live; the store count saturates.
   always_comb begin
      store_count_d = store_count_q;
      cycle_count_d = cycle_count_q;
      if (running) cycle_count_d = cycle_count_q + 32'd1;
      if (store_vld && (store_count_q != STORE_COUNT_MAX)) store_count_d = store_count_q + 16'd1;
   end

   // Counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         store_count_q <= '0;
         cycle_count_q <= '0;
      end else begin
         store_count_q <= store_count_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   store_log_fifo #(
      .DEPTH   (LOG_DEPTH),
      .entry_t (store_entry_t)
   ) u_log (
      .clk        (clk),
      .rst_n      (reset),
      .push_i     (store_vld),
      .din_i      (log_din),
      .pop_i      (log_pop),
      .full_o     (log_full_unused),
      .empty_o    (log_empty),
      .head_o     (log_head),
      .overflow_o (log_overflow)
   );

   assign done        = done_q;
   assign pass        = pass_q;
   assign fail        = fail_q;
   assign timeout     = timeout_q;
   assign store_count = store_count_q;
   assign cycle_count = cycle_count_q;
   assign log_valid   = !log_empty;
   assign log_addr    = log_head.addr;
   assign log_data    = log_head.data;

endmodule

// File: tb/tb_store_checker.sv
// Bench for store_checker: a queue-based behavioural model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_store_checker;

   localparam int TMO   = 16;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_write;
   logic [31:0] data_adr;
   logic [31:0] write_data;
   logic        log_pop;

   logic        done, pass, fail, timeout;
   logic [15:0] store_count;
   logic [31:0] cycle_count;
   logic        log_valid;
   logic [31:0] log_addr, log_data;
   logic        log_overflow;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   store_checker #(
      .PASS_ADDR    (32'd100),
      .PASS_DATA    (32'd7),
      .SCRATCH_ADDR (32'd96),
      .TIMEOUT      (TMO),
      .LOG_DEPTH    (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (rst_n),
      .MemWrite     (mem_write),
      .DataAdr      (data_adr),
      .WriteData    (write_data),
      .log_pop      (log_pop),
      .done         (done),
      .pass         (pass),
      .fail         (fail),
      .timeout      (timeout),
      .store_count  (store_count),
      .cycle_count  (cycle_count),
      .log_valid    (log_valid),
      .log_addr     (log_addr),
      .log_data     (log_data),
      .log_overflow (log_overflow)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_pass, m_fail, m_tmo, m_ovf;
   int          m_stores, m_cycles;
   logic [63:0] m_log[$];

   always @(posedge clk or negedge rst_n) begin : model
      bit finished, popped, is_store;
      if (!rst_n) begin
         m_pass = 0; m_fail = 0; m_tmo = 0; m_ovf = 0;
         m_stores = 0; m_cycles = 0;
         m_log.delete();
      end else begin
         finished = m_pass || m_fail || m_tmo;
         popped   = log_pop && (m_log.size() > 0);
         is_store = !finished && mem_write;
         if (!finished) m_cycles++;
         if (is_store) begin
            if (m_stores < 65535) m_stores++;
            if (data_adr == 100 && write_data == 7) m_pass = 1;
            else if (data_adr != 96)                m_fail = 1;
         end
         if (!finished && !m_pass && !m_fail && m_cycles == TMO) m_tmo = 1;
         if (popped) void'(m_log.pop_front());
         if (is_store) begin
            if (m_log.size() < DEPTH) m_log.push_back({data_adr, write_data});
            else                      m_ovf = 1;
         end
      end
   end

   // Compare every cycle, on the falling edge.
   always @(negedge clk) begin : compare
      check("cmp_done",     done,         m_pass || m_fail || m_tmo);
      check("cmp_pass",     pass,         m_pass);
      check("cmp_fail",     fail,         m_fail);
      check("cmp_timeout",  timeout,      m_tmo);
      check("cmp_stores",   store_count,  m_stores);
      check("cmp_cycles",   cycle_count,  m_cycles);
      check("cmp_valid",    log_valid,    m_log.size() != 0);
      check("cmp_overflow", log_overflow, m_ovf);
      if (m_log.size() != 0 && log_valid) check("cmp_head", {log_addr, log_data}, m_log[0]);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input bit pop);
      mem_write  = 1'b1;
      data_adr   = a;
      write_data = d;
      log_pop    = pop;
      tick();
      mem_write  = 1'b0;
      log_pop    = 1'b0;
   endtask

   task automatic pop_check(input string name, input logic [31:0] a, input logic [31:0] d);
      check({name, "_valid"}, log_valid, 1'b1);
      check({name, "_addr"},  log_addr,  a);
      check({name, "_data"},  log_data,  d);
      log_pop = 1'b1;
      tick();
      log_pop = 1'b0;
   endtask

   // Called just after a rising edge: pulls reset low, checks the cleared state, releases.
   task automatic do_reset(input string name);
      rst_n = 1'b0;
      #1;
      check({name, "_done"},  done,         1'b0);
      check({name, "_flags"}, {pass, fail, timeout}, 3'b000);
      check({name, "_cnt"},   store_count,  16'd0);
      check({name, "_cyc"},   cycle_count,  32'd0);
      check({name, "_valid"}, log_valid,    1'b0);
      check({name, "_ovf"},   log_overflow, 1'b0);
      check({name, "_head"},  {log_addr, log_data}, 64'd0);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b1;
      mem_write  = 1'b0;
      log_pop    = 1'b0;
      data_adr   = '0;
      write_data = '0;
      #1 rst_n   = 1'b0;
      tick();
      do_reset("rst_init");

      // Pass run: two scratch stores then the pass store.
      store(32'd96, 32'd3, 1'b0);
      store(32'd96, 32'd5, 1'b0);
      check("pass_early_done", done, 1'b0);
      store(32'd100, 32'd7, 1'b0);
      check("pass_flag",  pass, 1'b1);
      check("pass_done",  done, 1'b1);
      check("pass_nofail", {fail, timeout}, 2'b00);
      check("pass_cnt",   store_count, 16'd3);
      check("pass_cyc",   cycle_count, 32'd3);
      pop_check("pass_pop0", 32'd96,  32'd3);
      pop_check("pass_pop1", 32'd96,  32'd5);
      pop_check("pass_pop2", 32'd100, 32'd7);
      check("pass_empty",  log_valid,   1'b0);
      check("pass_frozen", cycle_count, 32'd3);

      // Wrong data at the pass address, then a late pass store that is ignored.
      tick();
      do_reset("rst_wd");
      store(32'd100, 32'd6, 1'b0);
      check("wd_fail", fail, 1'b1);
      check("wd_pass", pass, 1'b0);
      check("wd_cnt",  store_count, 16'd1);
      store(32'd100, 32'd7, 1'b0);
      check("wd_cnt_hold", store_count, 16'd1);
      check("wd_pass_hold", pass, 1'b0);
      pop_check("wd_pop0", 32'd100, 32'd6);
      check("wd_no_new", log_valid, 1'b0);

      // Illegal address.
      do_reset("rst_ill");
      store(32'd200, 32'd7, 1'b0);
      check("ill_fail", fail, 1'b1);
      check("ill_addr", log_addr, 32'd200);
      check("ill_data", log_data, 32'd7);

      // Watchdog with no stores.
      tick();
      do_reset("rst_wdg");
      repeat (TMO - 1) tick();
      check("wdg_before", timeout, 1'b0);
      check("wdg_cyc15",  cycle_count, 32'd15);
      tick();
      check("wdg_tmo",   timeout, 1'b1);
      check("wdg_done",  done, 1'b1);
      check("wdg_cyc16", cycle_count, 32'd16);
      repeat (3) tick();
      check("wdg_hold", cycle_count, 32'd16);

      // Pass store on the expiry cycle wins over the watchdog.
      do_reset("rst_race");
      repeat (TMO - 1) tick();
      store(32'd100, 32'd7, 1'b0);
      check("race_pass", pass, 1'b1);
      check("race_tmo",  timeout, 1'b0);
      check("race_cyc",  cycle_count, 32'd16);
      check("race_cnt",  store_count, 16'd1);

      // FIFO overflow: six scratch stores into a four-entry log.
      tick();
      do_reset("rst_ovf");
      for (int i = 1; i <= 4; i++) store(32'd96, 32'(i), 1'b0);
      check("ovf_none4", log_overflow, 1'b0);
      store(32'd96, 32'd5, 1'b0);
      check("ovf_set5", log_overflow, 1'b1);
      store(32'd96, 32'd6, 1'b0);
      check("ovf_cnt", store_count, 16'd6);
      for (int i = 1; i <= 4; i++) pop_check("ovf_pop", 32'd96, 32'(i));
      check("ovf_empty", log_valid, 1'b0);
      check("ovf_sticky", log_overflow, 1'b1);

      // Pop held during the fifth store: push and pop both complete.
      do_reset("rst_pp");
      for (int i = 11; i <= 14; i++) store(32'd96, 32'(i), 1'b0);
      store(32'd96, 32'd15, 1'b1);
      check("pp_no_ovf", log_overflow, 1'b0);
      check("pp_cnt",    store_count, 16'd5);
      for (int i = 12; i <= 15; i++) pop_check("pp_pop", 32'd96, 32'(i));
      check("pp_empty", log_valid, 1'b0);

      // Reset mid-run after two scratch stores.
      do_reset("rst_pre_mid");
      store(32'd96, 32'd1, 1'b0);
      store(32'd96, 32'd2, 1'b0);
      check("mid_cnt2",  store_count, 16'd2);
      check("mid_valid", log_valid, 1'b1);
      do_reset("rst_mid");
      store(32'd100, 32'd7, 1'b0);
      check("mid_pass", pass, 1'b1);
      check("mid_cnt",  store_count, 16'd1);
      check("mid_cyc",  cycle_count, 32'd1);
      pop_check("mid_pop", 32'd100, 32'd7);
      check("mid_empty", log_valid, 1'b0);

      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
